// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for eight requesters sharing one byte-wide resource.
// Grants are held for a bounded tenure, then priority rotates past the owner.
module rr_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Req,
    input  logic       Done,
    output logic [7:0] Grant,
    output logic [2:0] Sel,
    output logic       BusValid
);

    // state | meaning
    // IDLE  | no owner, Grant=0, waiting for any request
    // BUSY  | owner=Sel holds the resource, tenure counter running
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] HOLD = 4'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [2:0] last, last_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] grant_nxt;
    logic [2:0] sel_nxt;
    logic       bv_nxt;
    logic [2:0] base;
    logic [2:0] win;
    logic       found;
    logic       end_evt;

    // On an end event the owner becomes the new lowest-priority index.
    assign base    = (state == BUSY) ? Sel : last;
    assign end_evt = Done || !Req[Sel] || (cnt == HOLD);

    always_comb begin
        found = 1'b0;
        win   = base;
        for (int k = 1; k <= 8; k++) begin
            if (!found && Req[base + 3'(k)]) begin
                found = 1'b1;
                win   = base + 3'(k);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        grant_nxt = Grant;
        sel_nxt   = Sel;
        bv_nxt    = BusValid;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = 8'b1 << win;
                    sel_nxt   = win;
                    bv_nxt    = 1'b1;
                    cnt_nxt   = 4'd1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!end_evt) begin
                    cnt_nxt = cnt + 4'd1;
                end else begin
                    last_nxt = Sel;
                    if (found) begin
                        grant_nxt = 8'b1 << win;
                        sel_nxt   = win;
                        cnt_nxt   = 4'd1;
                    end else begin
                        grant_nxt = 8'h00;
                        bv_nxt    = 1'b0;
                        cnt_nxt   = 4'd0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 3'd7;
            cnt      <= 4'd0;
            Grant    <= 8'h00;
            Sel      <= 3'd0;
            BusValid <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            Grant    <= grant_nxt;
            Sel      <= sel_nxt;
            BusValid <= bv_nxt;
        end
    end

endmodule
